// File: rtl/div_ctrl_pkg.sv
// Shared MULT-DIV definitions: FSM state encoding, op encoding, overflow dividend.
package div_ctrl_pkg;

  localparam int unsigned MD_XLEN = 32;
  localparam int unsigned CNT_W   = 4;

  localparam logic OP_DIV = 1'b1;
  localparam logic OP_REM = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Most-negative dividend (1 << (xlen-1)) that overflows when divided by -1.
  function automatic logic [63:0] ovf_dividend(input int unsigned xlen);
    return 64'd1 << (xlen - 1);
  endfunction

endpackage

// File: rtl/div_ctrl_cache.sv
// One-entry result cache: tag (op, a, b) plus data, with combinational lookup.
module div_ctrl_cache
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_op,
  input  logic [XLEN-1:0] lookup_a,
  input  logic [XLEN-1:0] lookup_b,
  output logic            hit_c,
  output logic [XLEN-1:0] data,
  input  logic            wr_en,
  input  logic            wr_op,
  input  logic [XLEN-1:0] wr_a,
  input  logic [XLEN-1:0] wr_b,
  input  logic [XLEN-1:0] wr_data
);

  logic            valid;
  logic            tag_op;
  logic [XLEN-1:0] tag_a;
  logic [XLEN-1:0] tag_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      tag_op <= 1'b0;
      tag_a  <= '0;
      tag_b  <= '0;
      data   <= '0;
    end else if (wr_en) begin
      valid  <= 1'b1;
      tag_op <= wr_op;
      tag_a  <= wr_a;
      tag_b  <= wr_b;
      data   <= wr_data;
    end
  end

  assign hit_c = valid && (tag_op == lookup_op) && (tag_a == lookup_a) && (tag_b == lookup_b);

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for a combinational signed divider with RISC-V
// special-case resolution and a one-entry replay cache.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = MD_XLEN,
  parameter int unsigned DIV_LAT  = 2,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic            div_operation,
  output logic            div_enable,
  input  logic [XLEN-1:0] div_result,
  input  logic            div_by_zero,
  input  logic            div_done,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_dbz
);

  localparam logic [XLEN-1:0] OVF_A = XLEN'(ovf_dividend(XLEN));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  div_a_d, div_b_d, rsp_data_d;
  logic             div_op_d, rsp_dbz_d;
  logic             accept_c, cache_hit_c, cache_wr_c, hit_raw_c;
  logic [XLEN-1:0]  cache_data;

  // Zero divisor is decoded locally; the divider's own flag is not needed.
  logic unused_ok;
  assign unused_ok = div_by_zero;

  div_ctrl_cache #(.XLEN(XLEN)) u_cache (
    .clk       (clk),
    .rst       (rst),
    .lookup_op (req_op),
    .lookup_a  (req_a),
    .lookup_b  (req_b),
    .hit_c     (hit_raw_c),
    .data      (cache_data),
    .wr_en     (cache_wr_c),
    .wr_op     (div_operation),
    .wr_a      (div_a),
    .wr_b      (div_b),
    .wr_data   (div_result)
  );

  assign cache_hit_c = CACHE_EN && hit_raw_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_dbz       <= 1'b0;
      div_enable    <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      div_operation <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready     <= (state_d == ST_IDLE);
      rsp_valid     <= (state_d == ST_RESP);
      rsp_data      <= rsp_data_d;
      rsp_dbz       <= rsp_dbz_d;
      div_enable    <= (state_d == ST_BUSY);
      div_a         <= div_a_d;
      div_b         <= div_b_d;
      div_operation <= div_op_d;
    end
  end

  // Next-state, counter and response decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_a_d    = div_a;
    div_b_d    = div_b;
    div_op_d   = div_operation;
    rsp_data_d = rsp_data;
    rsp_dbz_d  = rsp_dbz;
    cache_wr_c = 1'b0;
    accept_c   = (state_q == ST_IDLE) && req_valid && req_ready && !flush;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          div_a_d  = req_a;
          div_b_d  = req_b;
          div_op_d = req_op;
          if (req_b == '0) begin
            state_d    = ST_RESP;
            rsp_data_d = (req_op == OP_DIV) ? '1 : req_a;
            rsp_dbz_d  = 1'b1;
          end else if ((req_a == OVF_A) && (req_b == '1)) begin
            state_d    = ST_RESP;
            rsp_data_d = (req_op == OP_REM) ? '0 : req_a;
            rsp_dbz_d  = 1'b0;
          end else if (cache_hit_c) begin
            state_d    = ST_RESP;
            rsp_data_d = cache_data;
            rsp_dbz_d  = 1'b0;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(DIV_LAT - 1);
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (div_done) begin
          state_d    = ST_RESP;
          rsp_data_d = div_result;
          rsp_dbz_d  = 1'b0;
          cache_wr_c = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flushed operation is discarded, so it must not reach the cache.
    if (flush) begin
      state_d    = ST_IDLE;
      cache_wr_c = 1'b0;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table, corner sequences, random traffic.
module tb_div_ctrl;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DIV_LAT = 2;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_op, flush;
  logic [31:0] req_a, req_b, div_a, div_b, div_result, rsp_data;
  logic        div_operation, div_enable, div_by_zero, div_done;
  logic        rsp_valid, rsp_ready, rsp_dbz;
  logic        done_en;

  int checks = 0;
  int errors = 0;

  // Cache model: the last normally-divided request.
  logic        c_valid;
  logic        c_op;
  logic [31:0] c_a, c_b;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(XLEN), .DIV_LAT(DIV_LAT), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .div_a(div_a), .div_b(div_b), .div_operation(div_operation),
    .div_enable(div_enable), .div_result(div_result), .div_by_zero(div_by_zero),
    .div_done(div_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_dbz(rsp_dbz)
  );

  // Divider stand-in: poisons results for operands the controller should never send.
  always_comb begin
    if (div_b == 32'h0 || (div_a == MIN_NEG && div_b == 32'hFFFF_FFFF))
      div_result = 32'hDEAD_BEEF;
    else if (div_operation)
      div_result = 32'($signed(div_a) / $signed(div_b));
    else
      div_result = 32'($signed(div_a) % $signed(div_b));
  end
  assign div_by_zero = (div_b == 32'h0);
  assign div_done    = div_enable & done_en;

  function automatic logic [32:0] ref_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return {1'b1, (op ? 32'hFFFF_FFFF : a)};
    if (a == MIN_NEG && b == 32'hFFFF_FFFF) return {1'b0, (op ? a : 32'h0)};
    if (op) return {1'b0, 32'($signed(a) / $signed(b))};
    return {1'b0, 32'($signed(a) % $signed(b))};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input logic exp_dbz,
                        input int exp_lat, input int hold);
    int lat, en_cnt, w;
    w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    chk("req_ready_pre", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    chk("req_ready_after_accept", 32'(req_ready), 32'd0);
    lat = 1; en_cnt = 0;
    while (!rsp_valid && lat < 40) begin
      if (div_enable) begin
        en_cnt++;
        chk("div_a", div_a, a);
        chk("div_b", div_b, b);
        chk("div_operation", 32'(div_operation), 32'(op));
      end
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_dbz", 32'(rsp_dbz), 32'(exp_dbz));
    chk("div_enable_cycles", 32'(en_cnt), 32'(exp_lat - 1));
    chk("div_enable_at_rsp", 32'(div_enable), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", rsp_data, exp_data);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_take", 32'(rsp_valid), 32'd0);
    chk("req_ready_after_take", 32'(req_ready), 32'd1);
  endtask

  task automatic run(input logic op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [32:0] r;
    bit spec, hit;
    r    = ref_model(op, a, b);
    spec = (b == 32'h0) || (a == MIN_NEG && b == 32'hFFFF_FFFF);
    hit  = !spec && c_valid && c_op == op && c_a == a && c_b == b;
    do_req(op, a, b, r[31:0], r[32], (spec || hit) ? 1 : int'(DIV_LAT) + 1, hold);
    if (!spec && !hit) begin c_valid = 1'b1; c_op = op; c_a = a; c_b = b; end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[10];
  logic        r_op, last_op;
  logic [31:0] r_a, r_b, last_a, last_b;
  int          sel;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
    flush = 1'b0; rsp_ready = 1'b0; done_en = 1'b1;
    c_valid = 1'b0; c_op = 1'b0; c_a = '0; c_b = '0;

    vecs[0] = '{1'b1, 32'd100,        32'd7,         32'd14,        1'b0, 3};
    vecs[1] = '{1'b0, 32'd5,          32'd0,         32'd5,         1'b1, 1};
    vecs[2] = '{1'b1, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1};
    vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0, 1};
    vecs[5] = '{1'b1, 32'd100,        32'd7,         32'd14,        1'b0, 1};
    vecs[6] = '{1'b1, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0, 3};
    vecs[7] = '{1'b1, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0, 1};
    vecs[8] = '{1'b0, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b0, 3};
    vecs[9] = '{1'b1, 32'd100,        32'd7,         32'd14,        1'b0, 3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_dbz", 32'(rsp_dbz), 32'd0);
    chk("rst_div_enable", 32'(div_enable), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_dbz,
             vecs[i].exp_lat, (i == 0) ? 5 : 0);
      if (vecs[i].exp_lat == int'(DIV_LAT) + 1) begin
        c_valid = 1'b1; c_op = vecs[i].op; c_a = vecs[i].a; c_b = vecs[i].b;
      end
    end

    // Flush in the first BUSY cycle, then the same request must miss.
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd1000; req_b = 32'd10;
    tick();
    req_valid = 1'b0;
    chk("flush_busy_enable", 32'(div_enable), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("flush_div_enable", 32'(div_enable), 32'd0);
    chk("flush_req_ready", 32'(req_ready), 32'd1);
    repeat (3) tick();
    chk("flush_no_late_rsp", 32'(rsp_valid), 32'd0);
    run(1'b1, 32'd1000, 32'd10, 0);

    // Flush alongside an IDLE request blocks acceptance.
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd3; req_b = 32'd0; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("flush_idle_req_ready", 32'(req_ready), 32'd1);

    // Flush beats a pending response.
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd9; req_b = 32'd0;
    tick();
    req_valid = 1'b0;
    chk("resp_before_flush", 32'(rsp_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_resp_valid", 32'(rsp_valid), 32'd0);
    chk("flush_resp_req_ready", 32'(req_ready), 32'd1);

    // Divider finishing late: controller waits for div_done.
    done_en = 1'b0;
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd50; req_b = 32'd5;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    chk("stall_no_rsp", 32'(rsp_valid), 32'd0);
    chk("stall_enable", 32'(div_enable), 32'd1);
    done_en = 1'b1;
    tick();
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_rsp_data", rsp_data, 32'd10);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    c_valid = 1'b1; c_op = 1'b1; c_a = 32'd50; c_b = 32'd5;
    run(1'b1, 32'd50, 32'd5, 0);

    // Reset during BUSY clears outputs and the cache.
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd9; req_b = 32'd2;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_rsp_dbz", 32'(rsp_dbz), 32'd0);
    chk("midrst_div_enable", 32'(div_enable), 32'd0);
    chk("midrst_div_a", div_a, 32'd0);
    chk("midrst_div_b", div_b, 32'd0);
    chk("midrst_div_op", 32'(div_operation), 32'd0);
    rst = 1'b0;
    c_valid = 1'b0;
    tick();
    chk("midrst_req_ready_after", 32'(req_ready), 32'd1);
    run(1'b1, 32'd50, 32'd5, 0);

    last_op = 1'b0; last_a = '0; last_b = '0;
    for (int i = 0; i < 40; i++) begin
      r_op = 1'($urandom);
      sel  = $urandom_range(0, 9);
      if (sel == 0)      r_b = 32'h0;
      else if (sel == 1) r_b = 32'hFFFF_FFFF;
      else if (sel < 5)  r_b = 32'($urandom_range(1, 20));
      else               r_b = $urandom;
      r_a = ($urandom_range(0, 4) == 0) ? MIN_NEG : $urandom;
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        r_op = last_op; r_a = last_a; r_b = last_b;
      end
      run(r_op, r_a, r_b, $urandom_range(0, 2));
      last_op = r_op; last_a = r_a; last_b = r_b;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
